// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } muldiv_op_t;

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StCalc,
      StFix,
      StDone
   } muldiv_state_t;

   function automatic logic is_div(muldiv_op_t op);
      return op[2];
   endfunction

   function automatic logic a_signed(muldiv_op_t op);
      return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
   endfunction

   function automatic logic b_signed(muldiv_op_t op);
      return op inside {OpMul, OpMulh, OpDiv, OpRem};
   endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One combinational iteration: STEP_BITS shift-add multiply bits or STEP_BITS restoring
// divide bits. Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend}.
module riscv_muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STEP_BITS  = 1
) (
   input  logic [2*DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0]   operand,
   input  logic                    div_mode,
   output logic [2*DATA_WIDTH-1:0] acc_next,
   output logic [STEP_BITS-1:0]    q_bits
);

   localparam int unsigned W = DATA_WIDTH;
   localparam int unsigned S = STEP_BITS;

   logic [W-1:0]     hi;
   logic [W-1:0]     lo;
   logic [S-1:0]     digit;
   logic [W+S-1:0]   partial;
   logic [W+S-1:0]   mul_sum;
   logic [2*W+S-1:0] mul_cat;
   logic [W:0]       rem_w;
   logic [W-1:0]     dvd;
   logic [S-1:0]     qb;

   assign hi      = acc[2*W-1:W];
   assign lo      = acc[W-1:0];
   assign digit   = lo[S-1:0];
   assign partial = {{S{1'b0}}, operand} * {{W{1'b0}}, digit};
   assign mul_sum = {{S{1'b0}}, hi} + partial;
   assign mul_cat = {mul_sum, lo};

   // Remainder stays below the divisor, so the shifted value fits in W+1 bits.
   always_comb begin
      rem_w = {1'b0, hi};
      dvd   = lo;
      qb    = '0;
      for (int i = 0; i < int'(S); i++) begin
         rem_w = {rem_w[W-1:0], dvd[W-1]};
         dvd   = dvd << 1;
         qb    = qb << 1;
         if (rem_w >= {1'b0, operand}) begin
            rem_w = rem_w - {1'b0, operand};
            qb[0] = 1'b1;
         end
      end
   end

   always_comb begin
      if (div_mode) begin
         acc_next = {rem_w[W-1:0], dvd};
      end else begin
         acc_next = mul_cat[2*W+S-1:S];
      end
   end

   assign q_bits = qb;

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with RISC-V corner-case results.
// Define MULDIV_FAST_EN to finish zero/overflow corner cases right after PREP.
module riscv_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STEP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  kill,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned S    = STEP_BITS;
   localparam int unsigned N    = DATA_WIDTH / STEP_BITS;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

   muldiv_state_t  state_q, state_d;
   muldiv_op_t     op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   dsr_q, dsr_d;
   logic           neg_q, neg_d;
   logic [W-1:0]   result_q, result_d;

   logic           div_mode;
   logic           a_neg;
   logic           b_neg;
   logic           b_zero;
   logic [W-1:0]   abs_a;
   logic [W-1:0]   abs_b;
   logic [2*W-1:0] step_acc;
   logic [S-1:0]   step_q;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   lo_fix;
   logic [W-1:0]   hi_fix;
   logic [W-1:0]   fix_res;
   logic           corner;
   logic [W-1:0]   corner_res;

   assign div_mode = is_div(op_q);
   assign a_neg    = a_signed(op_q) & a_q[W-1];
   assign b_neg    = b_signed(op_q) & b_q[W-1];
   assign b_zero   = (b_q == '0);
   assign abs_a    = a_neg ? -a_q : a_q;
   assign abs_b    = b_neg ? -b_q : b_q;

   riscv_muldiv_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .STEP_BITS  (STEP_BITS)
   ) u_step (
      .acc      (acc_q),
      .operand  (dsr_q),
      .div_mode (div_mode),
      .acc_next (step_acc),
      .q_bits   (step_q)
   );

   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign lo_fix   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
   assign hi_fix   = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

`ifdef MULDIV_FAST_EN
   logic ovf;
   assign ovf = (op_q == OpDiv || op_q == OpRem) && (a_q == {1'b1, {(W-1){1'b0}}}) &&
                (b_q == '1);

   // Architected results for operations that need no iteration.
   always_comb begin
      corner_res = '0;
      if (div_mode) begin
         corner = b_zero | ovf;
         if (b_zero) begin
            corner_res = op_q[1] ? a_q : '1;
         end else begin
            corner_res = op_q[1] ? '0 : a_q;
         end
      end else begin
         corner = (a_q == '0) | b_zero;
      end
   end
`else
   assign corner     = 1'b0;
   assign corner_res = '0;
`endif

   always_comb begin
      fix_res = lo_fix;
      case (op_q)
         OpMul:                      fix_res = lo_fix;
         OpMulh, OpMulhsu, OpMulhu:  fix_res = prod_fix[2*W-1:W];
         OpDiv, OpDivu:              fix_res = lo_fix;
         OpRem, OpRemu:              fix_res = hi_fix;
         default:                    fix_res = lo_fix;
      endcase
      if (corner) begin
         fix_res = corner_res;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      dsr_d    = dsr_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               op_d    = muldiv_op_t'(op);
               a_d     = a;
               b_d     = b;
               state_d = StPrep;
            end
         end
         StPrep: begin
            if (kill) begin
               state_d = StIdle;
            end else begin
               cnt_d   = '0;
               acc_d   = {{W{1'b0}}, (div_mode ? abs_a : abs_b)};
               dsr_d   = div_mode ? abs_b : abs_a;
               // Divide-by-zero keeps the all-ones quotient unsigned; remainder follows a.
               if (div_mode) begin
                  neg_d = op_q[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
               end else begin
                  neg_d = a_neg ^ b_neg;
               end
               state_d = corner ? StFix : StCalc;
            end
         end
         StCalc: begin
            if (kill) begin
               state_d = StIdle;
            end else begin
               acc_d = div_mode ? {step_acc[2*W-1:S], step_q} : step_acc;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntW'(N - 1)) begin
                  state_d = StFix;
               end
            end
         end
         StFix: begin
            if (kill) begin
               state_d = StIdle;
            end else begin
               result_d = fix_res;
               state_d  = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         op_q     <= OpMul;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         dsr_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         dsr_q    <= dsr_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: directed vectors, monitor checks result and latency.
module tb_riscv_muldiv_unit;
   import muldiv_pkg::*;

   localparam int NormLat = 34;
`ifdef MULDIV_FAST_EN
   localparam int FastLat = 2;
`else
   localparam int FastLat = 34;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic        kill  = 1'b0;
   logic [2:0]  op    = 3'b000;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   riscv_muldiv_unit #(
      .DATA_WIDTH (32),
      .STEP_BITS  (1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .kill   (kill),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      logic [31:0] res;
      int          issue;
      int          lat;
      string       name;
   } exp_t;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      bit          corner;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string nm, input logic [31:0] r, input int lat);
      exp_t e;
      e.res   = r;
      e.issue = edge_cnt;
      e.lat   = lat;
      e.name  = nm;
      sb.push_back(e);
   endtask

   // Drives a request for one edge, then scrambles the inputs to prove they were latched.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic k);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      kill  = k;
      step(1);
      start = 1'b0;
      kill  = 1'b0;
      op    = ~o;
      a     = ~x;
      b     = 32'h5A5A_A5A5;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 80 && (busy || done); i++) step(1);
      if (busy || done) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: got busy=%0b done=%0b expected both 0", busy, done);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 80 && !done; i++) step(1);
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL wait_done: got done=0 expected done within 80 edges");
      end
   endtask

   task automatic run(input vec_t v);
      wait_idle();
      issue(v.op, v.a, v.b, 1'b0);
      push(v.name, v.res, v.corner ? FastLat : NormLat);
      wait_done();
   endtask

   task automatic add(input string nm, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] r, input bit c);
      vec_t v;
      v.name   = nm;
      v.op     = o;
      v.a      = x;
      v.b      = y;
      v.res    = r;
      v.corner = c;
      vecs.push_back(v);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with result %0h expected no done", result);
         end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, 64'(result), 64'(e.res));
            check({e.name, "_latency"}, 64'(edge_cnt - e.issue), 64'(e.lat));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_done;

      add("mulhu_max",    OpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      add("mulhsu_m1x2",  OpMulhsu, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0);
      add("mulh_min",     OpMulh,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
      add("mulh_m1xm1",   OpMulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
      add("mul_m1xm1",    OpMul,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      add("mulhu_carry",  OpMulhu,  32'h80000000, 32'h00000002, 32'h00000001, 1'b0);
      add("mul_a_zero",   OpMul,    32'h00000000, 32'h12345678, 32'h00000000, 1'b1);
      add("mulh_b_zero",  OpMulh,   32'h12345678, 32'h00000000, 32'h00000000, 1'b1);
      add("div_neg",      OpDiv,    32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA, 1'b0);
      add("rem_neg",      OpRem,    32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE, 1'b0);
      add("div_negdvs",   OpDiv,    32'h00000014, 32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0);
      add("rem_negdvs",   OpRem,    32'h00000014, 32'hFFFFFFFD, 32'h00000002, 1'b0);
      add("divu_zero",    OpDivu,   32'h00000064, 32'h00000000, 32'hFFFFFFFF, 1'b1);
      add("remu_zero",    OpRemu,   32'h00000064, 32'h00000000, 32'h00000064, 1'b1);
      add("div_zero_neg", OpDiv,    32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFFF, 1'b1);
      add("rem_zero_neg", OpRem,    32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFEC, 1'b1);
      add("div_ovf",      OpDiv,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      add("rem_ovf",      OpRem,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      add("divu_big",     OpDivu,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
      add("remu_big",     OpRemu,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
      add("divu_plain",   OpDivu,   32'h000003E8, 32'h00000007, 32'h0000008E, 1'b0);
      add("remu_plain",   OpRemu,   32'h000003E8, 32'h00000007, 32'h00000006, 1'b0);

      #12;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      step(1);

      // MUL with busy/done timing profile, then start during DONE
      issue(OpMul, 32'd7, 32'hFFFFFFFD, 1'b0);
      push("mul_7xm3", 32'hFFFFFFEB, NormLat);
      step(1);
      check("busy_edge1", 64'(busy), 64'd1);
      step(32);
      check("busy_edge33", 64'(busy), 64'd1);
      check("done_edge33", 64'(done), 64'd0);
      step(1);
      check("busy_edge34", 64'(busy), 64'd0);
      check("done_edge34", 64'(done), 64'd1);
      op    = OpMul;
      a     = 32'd3;
      b     = 32'd5;
      start = 1'b1;
      step(1);
      check("start_in_done_ignored", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);
      step(1);
      start = 1'b0;
      a     = 32'hFFFF0000;
      check("start_after_done", 64'(busy), 64'd1);
      push("mul_3x5_b2b", 32'h0000000F, NormLat);
      wait_done();

      foreach (vecs[i]) run(vecs[i]);

      // Start while busy is ignored
      wait_idle();
      issue(OpMulhu, 32'h00010000, 32'h00010000, 1'b0);
      push("mulhu_2p32", 32'h00000001, NormLat);
      step(5);
      op    = OpMul;
      a     = 32'd2;
      b     = 32'd2;
      start = 1'b1;
      step(1);
      start = 1'b0;
      check("busy_after_ignored_start", 64'(busy), 64'd1);
      wait_done();

      // Start and kill together in IDLE: start wins
      wait_idle();
      issue(OpDivu, 32'd1000, 32'd7, 1'b1);
      push("divu_with_kill", 32'h0000008E, NormLat);
      check("start_beats_kill", 64'(busy), 64'd1);
      wait_done();

      // Asynchronous reset mid-CALC
      wait_idle();
      issue(OpMul, 32'd9, 32'd9, 1'b0);
      step(10);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_result", 64'(result), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      step(1);
      issue(OpMul, 32'd3, 32'd5, 1'b0);
      push("mul_3x5_post_rst", 32'h0000000F, NormLat);
      wait_done();

      // Kill at CALC iteration 10
      wait_idle();
      issue(OpDivu, 32'd1000, 32'd7, 1'b0);
      step(11);
      kill = 1'b1;
      step(1);
      kill = 1'b0;
      check("kill_busy", 64'(busy), 64'd0);
      check("kill_result_kept", 64'(result), 64'h0000000F);
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) seen_done = 1'b1;
         step(1);
      end
      check("kill_no_done", 64'(seen_done), 64'd0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
